// File: rtl/log_arbiter.sv
// -----------------------------------------------------------------------------
// log_arbiter
// Shares one multi-cycle logarithm unit between NREQ requesters. A round-robin
// arbiter accepts one request at a time, launches the logarithm unit, waits for
// its completion (or a watchdog timeout) and returns the result to the winning
// requester, holding it until that requester accepts it.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   req_valid  : per-requester request level
//   req_x      : per-requester operands, requester i at [i*(N+1) +: N+1]
//   req_ready  : one-hot accept pulse (only in IDLE)
//   rsp_valid  : one-hot response valid, held until rsp_ready[id]
//   rsp_ready  : per-requester response accept
//   rsp_y      : shared result bus
//   rsp_err    : response is a watchdog timeout (rsp_y is then 0)
//   log_start  : start strobe to the logarithm unit (held through LAUNCH)
//   log_x      : operand to the logarithm unit
//   log_y      : result from the logarithm unit
//   log_done   : completion status from the logarithm unit (level or pulse)
//   busy       : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module log_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 8,
  parameter int P    = 16,
  parameter int TMO  = 1023
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*(N+1)-1:0]   req_x,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [P-1:0]            rsp_y,
  output logic                    rsp_err,
  output logic                    log_start,
  output logic [N:0]              log_x,
  input  logic [P-1:0]            log_y,
  input  logic                    log_done,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  // The watchdog reaches TMO on the cycle after it reads TMO-1.
  localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [N:0]      x_q, x_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [P-1:0]    rsp_y_q, rsp_y_d;
  logic            rsp_err_q, rsp_err_d;
  logic            log_start_q, log_start_d;
  logic            busy_q, busy_d;

  logic            found_s;
  logic [IW-1:0]   gidx_s;
  logic [NREQ-1:0] grant_s;
  logic            timeout_s;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int k = 0; k < NREQ; k++) begin
      v[k] = (int'(idx) == k);
    end
    return v;
  endfunction

  // Round-robin search: first valid requester at or after ptr_q, with wrap.
  always_comb begin
    int idx;
    found_s = 1'b0;
    gidx_s  = '0;
    grant_s = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s      = 1'b1;
        gidx_s       = IW'(idx);
        grant_s[idx] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accept pulse is combinational so that a request dropped before the edge
  // never sees a stale grant; it is forced low during reset.
  always_comb begin
    if ((state_q == S_IDLE) && reset) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign timeout_s = (wd_q == WD_LAST);

  // Next-state and datapath computation for all registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    wd_d        = wd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    log_start_d = log_start_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d     = S_LAUNCH;
          id_d        = gidx_s;
          x_d         = req_x[int'(gidx_s)*(N+1) +: (N+1)];
          wd_d        = '0;
          log_start_d = 1'b1;
          busy_d      = 1'b1;
          if (gidx_s == IW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gidx_s + IW'(1);
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_LAUNCH: begin
        // Timeout wins over everything, including a level done that never drops.
        if (timeout_s) begin
          state_d     = S_RESP;
          rsp_valid_d = to_onehot(id_q);
          rsp_y_d     = '0;
          rsp_err_d   = 1'b1;
          log_start_d = 1'b0;
        end else if (!log_done) begin
          // Done must be seen low once so a stale level done is not taken
          // as completion of this operation.
          state_d     = S_WAIT;
          log_start_d = 1'b0;
          wd_d        = wd_q + WW'(1);
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_WAIT: begin
        if (timeout_s) begin
          state_d     = S_RESP;
          rsp_valid_d = to_onehot(id_q);
          rsp_y_d     = '0;
          rsp_err_d   = 1'b1;
        end else if (log_done) begin
          state_d     = S_RESP;
          rsp_valid_d = to_onehot(id_q);
          rsp_y_d     = log_y;
          rsp_err_d   = 1'b0;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_RESP: begin
        // Only the owning requester's accept is honoured.
        if (rsp_ready[id_q]) begin
          state_d     = S_IDLE;
          rsp_valid_d = '0;
          busy_d      = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = '0;
        log_start_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      x_q         <= '0;
      wd_q        <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      log_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      wd_q        <= wd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      log_start_q <= log_start_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign log_start = log_start_q;
  assign log_x     = x_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_log_arbiter.sv
// -----------------------------------------------------------------------------
// tb_log_arbiter
// Directed-vector bench for log_arbiter. The logarithm unit is played by the
// bench itself (log_done / log_y driven from the stimulus sequence). Inputs
// change on the falling edge; registered outputs are checked there too, and the
// combinational accept pulse is checked 1 time unit after inputs change.
// -----------------------------------------------------------------------------
module tb_log_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 8;
  localparam int P    = 16;
  localparam int TMO  = 1023;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*(N+1)-1:0] req_x;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [P-1:0]          rsp_y;
  logic                  rsp_err;
  logic                  log_start;
  logic [N:0]            log_x;
  logic [P-1:0]          log_y;
  logic                  log_done;
  logic                  busy;

  int vec_cnt;
  int err_cnt;

  // Monitor counters (written only by the monitor process).
  int mon_multi_grant;
  int mon_grant_busy;
  int mon_launch_exit;
  int mon_resp_entry;
  logic mon_prev_start;
  logic mon_prev_rsp;

  log_arbiter #(.NREQ(NREQ), .N(N), .P(P), .TMO(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .log_start (log_start),
    .log_x     (log_x),
    .log_y     (log_y),
    .log_done  (log_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Watches grant exclusivity and FSM transitions, away from both clock edges.
  initial begin
    mon_multi_grant = 0;
    mon_grant_busy  = 0;
    mon_launch_exit = 0;
    mon_resp_entry  = 0;
    mon_prev_start  = 1'b0;
    mon_prev_rsp    = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if ($countones(req_ready) > 1) mon_multi_grant++;
      if (busy && (req_ready != 4'b0000)) mon_grant_busy++;
      if (mon_prev_start && !log_start && reset) mon_launch_exit++;
      if (!mon_prev_rsp && (rsp_valid != 4'b0000)) mon_resp_entry++;
      mon_prev_start = log_start;
      mon_prev_rsp   = (rsp_valid != 4'b0000);
    end
  end

  // One complete transaction with the unit finishing after 'dly' WAIT cycles.
  task automatic run_txn(input logic [3:0] g, input logic [8:0] x, input logic [15:0] y, input int dly);
    #1;
    check_eq("rr_grant", req_ready, g);
    tick();
    check_eq("rr_start", log_start, 1'b1);
    check_eq("rr_x", log_x, x);
    repeat (dly) tick();
    log_y    = y;
    log_done = 1'b1;
    tick();
    log_done = 1'b0;
    check_eq("rr_rsp_valid", rsp_valid, g);
    check_eq("rr_rsp_y", rsp_y, y);
    check_eq("rr_rsp_err", rsp_err, 1'b0);
    rsp_ready = g;
    tick();
    rsp_ready = 4'b0000;
    check_eq("rr_rsp_clear", rsp_valid, 4'b0000);
  endtask

  initial begin
    int le0;
    int re0;
    int bp_viol;
    vec_cnt   = 0;
    err_cnt   = 0;
    reset     = 1'b0;
    req_valid = 4'b0000;
    req_x     = {9'h0F3, 9'h1B1, 9'h022, 9'h145};
    rsp_ready = 4'b0000;
    log_y     = 16'h0000;
    log_done  = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 4'b0000);
    check_eq("rst_rsp_y", rsp_y, 16'h0000);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_log_start", log_start, 1'b0);
    check_eq("rst_log_x", log_x, 9'h000);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    reset    = 1'b1;
    log_done = 1'b1;   // level-type done, high while idle
    tick();

    // Single request on requester 2, level-type done
    le0 = mon_launch_exit;
    re0 = mon_resp_entry;
    req_valid = 4'b0100;
    #1;
    check_eq("s_grant", req_ready, 4'b0100);
    tick();
    check_eq("s_ready_low", req_ready, 4'b0000);
    check_eq("s_start", log_start, 1'b1);
    check_eq("s_log_x", log_x, 9'h1B1);
    check_eq("s_busy", busy, 1'b1);
    req_valid = 4'b0000;
    tick();
    check_eq("s_hold_launch", log_start, 1'b1);
    log_done = 1'b0;
    tick();
    check_eq("s_wait", log_start, 1'b0);
    repeat (18) tick();
    log_y    = 16'h5A3C;
    log_done = 1'b1;
    tick();
    check_eq("s_rsp_valid", rsp_valid, 4'b0100);
    check_eq("s_rsp_y", rsp_y, 16'h5A3C);
    check_eq("s_rsp_err", rsp_err, 1'b0);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    check_eq("s_rsp_clear", rsp_valid, 4'b0000);
    check_eq("s_idle", busy, 1'b0);
    tick();
    check_eq("lvl_launch_exits", mon_launch_exit - le0, 1);
    check_eq("lvl_resp_entries", mon_resp_entry - re0, 1);

    // Contention from ptr=0: order 0,1,2,3,0 with back-to-back grants
    log_done = 1'b0;
    reset    = 1'b0;
    repeat (2) tick();
    reset     = 1'b1;
    req_valid = 4'b1111;
    run_txn(4'b0001, 9'h145, 16'h1111, 1);
    run_txn(4'b0010, 9'h022, 16'h2222, 3);
    run_txn(4'b0100, 9'h1B1, 16'h3333, 1);
    run_txn(4'b1000, 9'h0F3, 16'h4444, 2);
    run_txn(4'b0001, 9'h145, 16'h5555, 1);

    // Response backpressure on requester 1, foreign rsp_ready bits ignored
    #1;
    check_eq("bp_grant", req_ready, 4'b0010);
    tick();
    tick();
    log_y    = 16'hBEEF;
    log_done = 1'b1;
    tick();
    log_done = 1'b0;
    check_eq("bp_rsp_valid", rsp_valid, 4'b0010);
    rsp_ready = 4'b1101;
    bp_viol   = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ((rsp_valid !== 4'b0010) || (rsp_y !== 16'hBEEF) || (req_ready !== 4'b0000)) bp_viol++;
    end
    check_eq("bp_stable", bp_viol, 0);
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = 4'b0000;
    check_eq("bp_release", rsp_valid, 4'b0000);

    // Watchdog timeout with done stuck high
    req_valid = 4'b0100;
    log_done  = 1'b1;
    log_y     = 16'h7777;
    #1;
    check_eq("tmo_grant", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0000;
    repeat (TMO - 1) tick();
    check_eq("tmo_not_early", rsp_valid, 4'b0000);
    tick();
    check_eq("tmo_rsp_valid", rsp_valid, 4'b0100);
    check_eq("tmo_rsp_err", rsp_err, 1'b1);
    check_eq("tmo_rsp_y", rsp_y, 16'h0000);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    log_done  = 1'b0;
    check_eq("tmo_clear", rsp_valid, 4'b0000);

    // Mid-operation reset in WAIT, then requester 3 from ptr=0
    req_valid = 4'b0001;
    #1;
    check_eq("mr_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick();
    check_eq("mr_in_wait", busy, 1'b1);
    reset = 1'b0;
    tick();
    check_eq("mr_busy", busy, 1'b0);
    check_eq("mr_log_start", log_start, 1'b0);
    check_eq("mr_rsp_valid", rsp_valid, 4'b0000);
    req_valid = 4'b1000;
    #1;
    check_eq("mr_no_grant_in_rst", req_ready, 4'b0000);
    reset = 1'b1;
    #1;
    check_eq("mr_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    check_eq("mr_log_x", log_x, 9'h0F3);
    tick();
    log_y    = 16'h1234;
    log_done = 1'b1;
    tick();
    log_done = 1'b0;
    check_eq("mr_rsp_valid3", rsp_valid, 4'b1000);
    check_eq("mr_rsp_y", rsp_y, 16'h1234);
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = 4'b0000;

    // Request dropped before the edge creates no transaction
    req_valid = 4'b0010;
    #1;
    check_eq("drop_ready", req_ready, 4'b0010);
    #1;
    req_valid = 4'b0000;
    tick();
    check_eq("drop_busy", busy, 1'b0);
    tick();
    check_eq("drop_start", log_start, 1'b0);

    check_eq("mon_multi_grant", mon_multi_grant, 0);
    check_eq("mon_grant_busy", mon_grant_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
